fetch_decode_link: RTL and testbench

- Receiving end of the instruction fetch interface. Captures the fetched instruction and PC+1 into the IF/ID pipeline register.
- Drives the fetch-control signals back to fetch: stall, alt_pc and alt_pc_ctrl (branch redirect), and hlt.
- Sits between fetch and decode. Owns load-use stall detection, wrong-path squashing after a taken branch, and halt detection.
- Instruction memory is a synchronous-read memory, so an instruction arrives one cycle after its address.

---
 rtl/fetch_decode_link.sv | 111 +++++++++++
 tb/tb_fetch_decode_link.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_link.sv
// IF/ID link: captures fetched instruction/PC+1 into the IF/ID register and
// drives stall, redirect and halt control back to fetch.
module fetch_decode_link #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [3:0]  HLT_OP       = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_plus_1_in,
    input  logic        ex_br_taken,
    input  logic [15:0] ex_br_target,
    input  logic        ex_is_load,
    input  logic [3:0]  ex_rd,
    output logic        stall,
    output logic [15:0] alt_pc,
    output logic        alt_pc_ctrl,
    output logic        hlt,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus_1_out,
    output logic        id_valid
);
    // Counter wide enough to hold FLUSH_CYCLES and the reset value of 1.
    localparam int CW = $clog2(FLUSH_CYCLES + 2);

    typedef enum logic [1:0] {RUN, FLUSH, STALL, HALT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] flush_cnt, flush_cnt_nxt;
    logic          valid, valid_nxt;
    logic          hlt_nxt;
    logic          load;
    logic          redirect;
    logic          hz;
    logic          halt_hit;

    // Redirect address is always the EX target; fetch decides via alt_pc_ctrl.
    assign alt_pc      = ex_br_target;
    assign redirect    = ex_br_taken && (state != HALT);
    assign hz          = valid && ex_is_load && (ex_rd != 4'd0) &&
                         ((ex_rd == instr_out[7:4]) || (ex_rd == instr_out[3:0]));
    assign alt_pc_ctrl = rst_n && redirect;
    // A redirect squashes the dependent instruction anyway, so it overrides stall.
    assign stall       = rst_n && hz && !redirect && (state != HALT);
    assign id_valid    = valid && !stall && (state != HALT);
    assign halt_hit    = valid && !stall && !redirect && (state != HALT) &&
                         (instr_out[15:12] == HLT_OP);

    // Next-state selection in priority order: redirect, load-use, halt, capture.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        valid_nxt     = valid;
        hlt_nxt       = hlt;
        load          = 1'b0;
        if (state != HALT) begin
            if (redirect) begin
                // Word arriving now is wrong-path; capture it as a bubble.
                load          = 1'b1;
                valid_nxt     = 1'b0;
                flush_cnt_nxt = CW'(FLUSH_CYCLES);
                state_nxt     = FLUSH;
            end else if (hz) begin
                // Hold IF/ID; hazard is re-evaluated next cycle.
                state_nxt = STALL;
            end else if (halt_hit) begin
                hlt_nxt   = 1'b1;
                state_nxt = HALT;
            end else begin
                load = 1'b1;
                if (flush_cnt != '0) begin
                    // Last flush slot clears the counter and captures the
                    // first correct-path word as valid.
                    flush_cnt_nxt = flush_cnt - CW'(1);
                    valid_nxt     = (flush_cnt == CW'(1));
                    state_nxt     = (flush_cnt == CW'(1)) ? RUN : FLUSH;
                end else begin
                    valid_nxt = 1'b1;
                    state_nxt = RUN;
                end
            end
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= CW'(1);
            valid     <= 1'b0;
            hlt       <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            valid     <= valid_nxt;
            hlt       <= hlt_nxt;
        end
    end

    // IF/ID data register; loads only on capture edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_out     <= 16'h0000;
            pc_plus_1_out <= 16'h0000;
        end else if (load) begin
            instr_out     <= instr_in;
            pc_plus_1_out <= pc_plus_1_in;
        end
    end

endmodule

// File: tb/tb_fetch_decode_link.sv
// Scoreboard bench for fetch_decode_link: directed test-plan sequences then
// random traffic, checked against a behavioural model of the IF/ID link.
module tb_fetch_decode_link;
    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr_in, pc_plus_1_in, ex_br_target;
    logic        ex_br_taken, ex_is_load;
    logic [3:0]  ex_rd;
    logic        stall, alt_pc_ctrl, hlt, id_valid;
    logic [15:0] alt_pc, instr_out, pc_plus_1_out;

    always #5 clk = ~clk;

    fetch_decode_link #(.FLUSH_CYCLES(FLUSH_CYCLES), .HLT_OP(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .pc_plus_1_in(pc_plus_1_in),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .stall(stall), .alt_pc(alt_pc),
        .alt_pc_ctrl(alt_pc_ctrl), .hlt(hlt), .instr_out(instr_out),
        .pc_plus_1_out(pc_plus_1_out), .id_valid(id_valid)
    );

    typedef struct {
        logic        stall, apc_ctrl, hlt, idv, chk_data;
        logic [15:0] apc, instr, pc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Model: what decode currently holds, whether it is real, how many more
    // captures are still wrong-path, and whether the machine has halted.
    bit          m_halted = 1'b0, m_valid = 1'b0, m_fresh = 1'b1;
    logic [15:0] m_instr = 16'h0, m_pc = 16'h0;
    int          m_dead = 0;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, push the expected outputs, advance the model.
    task automatic step(input logic r, input logic [15:0] i, input logic [15:0] p,
                        input logic b, input logic [15:0] t, input logic l,
                        input logic [3:0] d);
        exp_t e;
        bit redir, hz, stl;
        @(posedge clk); #1;
        rst_n = r; instr_in = i; pc_plus_1_in = p; ex_br_taken = b;
        ex_br_target = t; ex_is_load = l; ex_rd = d;

        redir = b && !m_halted;
        hz    = m_valid && l && (d != 4'd0) && (d == m_instr[7:4] || d == m_instr[3:0]);
        stl   = r && hz && !redir && !m_halted;
        e.stall    = stl;
        e.apc_ctrl = r && redir;
        e.apc      = t;
        e.hlt      = m_halted;
        e.idv      = m_valid && !stl && !m_halted;
        e.chk_data = m_fresh || (m_valid && !m_halted);
        e.instr    = m_instr;
        e.pc       = m_pc;
        q.push_back(e);

        if (!r) begin
            m_halted = 1'b0; m_valid = 1'b0; m_instr = 16'h0; m_pc = 16'h0;
            m_dead = 0; m_fresh = 1'b1;
        end else begin
            m_fresh = 1'b0;
            if (m_halted) begin
            end else if (redir) begin
                m_valid = 1'b0; m_instr = i; m_pc = p; m_dead = FLUSH_CYCLES - 1;
            end else if (hz) begin
            end else if (m_valid && m_instr[15:12] == 4'hF) begin
                m_halted = 1'b1;
            end else begin
                m_instr = i; m_pc = p;
                m_valid = (m_dead == 0);
                if (m_dead > 0) m_dead--;
            end
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk1("stall", stall, e.stall);
                chk1("alt_pc_ctrl", alt_pc_ctrl, e.apc_ctrl);
                chk16("alt_pc", alt_pc, e.apc);
                chk1("hlt", hlt, e.hlt);
                chk1("id_valid", id_valid, e.idv);
                if (e.chk_data) begin
                    chk16("instr_out", instr_out, e.instr);
                    chk16("pc_plus_1_out", pc_plus_1_out, e.pc);
                end
            end
        end
    end

    initial begin
        logic        r, b, l;
        logic [3:0]  op, d;
        logic [15:0] ins, mi;
        rst_n = 1'b0; instr_in = 16'h0; pc_plus_1_in = 16'h0; ex_br_taken = 1'b0;
        ex_br_target = 16'h0; ex_is_load = 1'b0; ex_rd = 4'h0;
        repeat (2) @(posedge clk);

        // Reset, then a plain stream.
        step(0, 16'h0000, 16'h0000, 0, 16'h0, 0, 4'h0);
        step(1, 16'h1123, 16'h0001, 0, 16'h0, 0, 4'h0);
        step(1, 16'h2456, 16'h0002, 0, 16'h0, 0, 4'h0);
        step(1, 16'h3789, 16'h0003, 0, 16'h0, 0, 4'h0);
        // Load-use on rt, then ex_rd=0 (no stall).
        step(1, 16'h1234, 16'h0004, 0, 16'h0, 0, 4'h0);
        step(1, 16'h5000, 16'h0005, 0, 16'h0, 1, 4'h4);
        step(1, 16'h5000, 16'h0005, 0, 16'h0, 0, 4'h0);
        step(1, 16'h1234, 16'h0006, 0, 16'h0, 0, 4'h0);
        step(1, 16'h6000, 16'h0007, 0, 16'h0, 1, 4'h0);
        // Taken branch, flush window.
        step(1, 16'h7000, 16'h0008, 1, 16'h0040, 0, 4'h0);
        step(1, 16'h7001, 16'h0009, 0, 16'h0, 0, 4'h0);
        step(1, 16'h7002, 16'h0041, 0, 16'h0, 0, 4'h0);
        step(1, 16'h7003, 16'h0042, 0, 16'h0, 0, 4'h0);
        // Hazard and branch together.
        step(1, 16'h1234, 16'h0043, 0, 16'h0, 0, 4'h0);
        step(1, 16'h2222, 16'h0044, 1, 16'h0080, 1, 4'h3);
        step(1, 16'h2223, 16'h0045, 0, 16'h0, 0, 4'h0);
        step(1, 16'h2224, 16'h0081, 0, 16'h0, 0, 4'h0);
        step(1, 16'h2225, 16'h0082, 0, 16'h0, 0, 4'h0);
        // Halt, branch ignored, reset clears.
        step(1, 16'hF000, 16'h0083, 0, 16'h0, 0, 4'h0);
        step(1, 16'h3000, 16'h0084, 0, 16'h0, 0, 4'h0);
        step(1, 16'h3001, 16'h0085, 0, 16'h0, 0, 4'h0);
        step(1, 16'h3002, 16'h0086, 1, 16'h0100, 0, 4'h0);
        step(0, 16'h0000, 16'h0000, 0, 16'h0, 0, 4'h0);
        step(1, 16'h1111, 16'h0001, 0, 16'h0, 0, 4'h0);
        // HLT in IF/ID while a redirect arrives: redirect wins.
        step(1, 16'hF000, 16'h0002, 0, 16'h0, 0, 4'h0);
        step(1, 16'h4000, 16'h0003, 1, 16'h0200, 0, 4'h0);
        step(1, 16'h4001, 16'h0004, 0, 16'h0, 0, 4'h0);
        step(1, 16'h4002, 16'h0201, 0, 16'h0, 0, 4'h0);
        step(1, 16'h4003, 16'h0202, 0, 16'h0, 0, 4'h0);
        // Reset while flush_cnt=2.
        step(1, 16'h4004, 16'h0203, 1, 16'h0300, 0, 4'h0);
        step(0, 16'h4005, 16'h0204, 0, 16'h0, 0, 4'h0);
        step(1, 16'h4006, 16'h0001, 0, 16'h0, 0, 4'h0);
        step(1, 16'h4007, 16'h0002, 0, 16'h0, 0, 4'h0);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            r   = m_halted ? ($urandom_range(3) != 0) : ($urandom_range(99) != 0);
            op  = ($urandom_range(29) == 0) ? 4'hF : 4'($urandom_range(14));
            ins = {op, 12'($urandom)};
            b   = ($urandom_range(6) == 0);
            l   = ($urandom_range(2) == 0);
            mi  = m_instr;
            case ($urandom_range(3))
                0: d = mi[7:4];
                1: d = mi[3:0];
                default: d = 4'($urandom);
            endcase
            step(r, ins, 16'($urandom), b, 16'($urandom), l, d);
        end

        @(negedge clk); #1;
        chk16("scoreboard_drain", 16'(q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
